ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-port arbiter and sequencer that shares the single asynchronous-strobe data RAM between requester 0 (instruction fetch / I-cache refill) and requester 1 (data port / D-cache).
- Accepts valid/ready requests and applies round-robin priority.
- Drives the RAM chip-enable, write-enable, output-enable and byte/word strobes for a fixed number of access cycles, controls the shared tri-state data bus, and returns one response pulse per request.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be 32.
- WAIT_CYCLES, 2, cycles the RAM strobes are held per access; range 1..15.
- START_ADDRESS, 32'h10010000, base byte address of the RAM window.
- MEM_BYTES, 128, RAM window size in bytes; used only by the optional range check.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  2  request valid, one bit per requester.
- req_ready  out  2  request accepted this cycle, one-hot or zero.
- req_we  in  2  1 = write, 0 = read, per requester.
- req_bw  in  2  1 = word access, 0 = byte access, per requester.
- req_addr  in  2xADDR_W  byte address, per requester.
- req_wdata  in  2xDATA_W  write data; a byte write uses [7:0].
- rsp_valid  out  2  one-cycle response pulse to the request owner.
- rsp_rdata  out  DATA_W  read data, qualified by rsp_valid.
- rsp_err  out  1  range error, qualified by rsp_valid.
- mem_addr  out  ADDR_W  RAM byte address.
- mem_data  inout  DATA_W  shared tri-state RAM data bus.
- mem_ce_n  out  1  RAM chip enable, active-low.
- mem_we_n  out  1  RAM write enable, active-low.
- mem_oe_n  out  1  RAM output enable, active-low.
- mem_bw  out  1  RAM word (1) / byte (0) select.

Behaviour:
- Reset values (synchronous; also apply when reset occurs mid-access):
  - state = IDLE; rr pointer = 0 (requester 0 has priority).
  - mem_ce_n = mem_we_n = mem_oe_n = 1; mem_bw = 0; mem_addr = 0; mem_data released to 'z.
  - req_ready = 0; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0.
  - An in-flight access is dropped and no response is issued for it.
- State machine: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - The grant is combinational from req_valid and the rr pointer. If both requesters are valid, the pointer selects; otherwise the single valid requester wins.
  - req_ready[g] = 1 in the same cycle, and the handshake completes when valid and ready are both high.
  - On that edge, addr, we, bw, wdata and the owner ID are latched, the wait counter is loaded with WAIT_CYCLES-1, and the state moves to ACCESS.
- ACCESS:
  - mem_ce_n = 0 and mem_addr and mem_bw come from the latched values.
  - Read: mem_oe_n = 0 and mem_we_n = 1; the arbiter does not drive the bus.
  - Write: mem_we_n = 0, mem_oe_n = 1, and mem_data is driven with the latched wdata.
  - The counter decrements each cycle. On the edge where the count is 0:
    - a read captures mem_data, zero-extended from [7:0] when bw = 0;
    - the state moves to RESP.
- RESP:
  - All strobes are high and the bus is released.
  - rsp_valid[owner] = 1 for exactly one cycle, for both reads and writes (a write acknowledge carries rdata = 0).
  - The rr pointer moves to the other requester, then the state returns to IDLE.
- Timing:
  - Handshake at cycle T, ACCESS during T+1..T+WAIT_CYCLES, rsp_valid at T+WAIT_CYCLES+1.
  - Peak throughput is one request per WAIT_CYCLES+2 cycles.
- Bus turnaround: the arbiter never drives mem_data while mem_oe_n = 0. At least two strobe-idle cycles (RESP, IDLE) separate consecutive accesses.
- req_ready is 0 outside IDLE. Requesters hold their valid and payload until accepted.
- A requester left waiting is granted next: worst-case wait is one full access.
- Addresses are passed unmodified; alignment is the requester's responsibility.

Optional Feature:
- Macro: RAM_ARB_ERR_EN.
- Defined:
  - In IDLE the latched address is range-checked.
  - A word access is an error if addr < START_ADDRESS or addr+4 > START_ADDRESS+MEM_BYTES.
  - A byte access is an error if addr < START_ADDRESS or addr+1 > START_ADDRESS+MEM_BYTES.
  - On error, IDLE goes straight to RESP (no ACCESS, strobes stay high), with rsp_err = 1 and rsp_rdata = 0.
- Undefined: no check is made, rsp_err is tied to 0, and every request goes through ACCESS.

Decomposition:
- Package ram_arb_pkg:
  - state enum {IDLE, ACCESS, RESP};
  - req_t struct {we, bw, addr, wdata};
  - N_REQ = 2 constant;
  - wait-counter width function.
- Sub-module ram_arb_rr: two-way round-robin grant logic, i.e. valid[1:0] + pointer -> one-hot grant.

Test Plan:
- Single read: req1 read, word, addr 32'h10010004, RAM preloaded with 32'hDEADBEEF, WAIT_CYCLES = 2 -> mem_oe_n low for 2 cycles, rsp_valid[1] at T+3, rsp_rdata = 32'hDEADBEEF.
- Byte write then read: req0 writes wdata 32'h000000A5, bw = 0, addr 32'h10010010 -> mem_we_n low for 2 cycles and mem_data = 32'h000000A5. A word read of the same address then returns [7:0] = 8'hA5.
- Simultaneous requests: both valid at reset exit -> grant order 0, 1, 0, 1. Each rsp_valid goes only to its owner, and no requester is granted twice in a row while the other waits.
- Bus discipline: a write immediately followed by a read -> mem_data is 'z whenever mem_oe_n = 0, and the strobes are high for ≥2 cycles between accesses.
- Reset mid-operation: reset_n low during the 1st ACCESS cycle of a write -> on the next edge all strobes are high, the bus is 'z, no rsp_valid is issued, and the state is IDLE.
- With RAM_ARB_ERR_EN defined: word read at 32'h1001007E -> no ce_n pulse, rsp_valid pulses one cycle after the handshake, rsp_err = 1, rsp_rdata = 0.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the two-requester RAM arbiter.
package ram_arb_pkg;

  localparam int N_REQ      = 2;
  localparam int ADDR_MAX_W = 32;

  // Arbiter sequencer states: the debug port exposes these encodings.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Request payload latched at the handshake.
  typedef struct packed {
    logic                  we;
    logic                  bw;
    logic [ADDR_MAX_W-1:0] addr;
    logic [31:0]           wdata;
  } req_t;

  // Width of a down-counter that is loaded with wait_cycles-1.
  function automatic int wait_cnt_w(input int wait_cycles);
    return (wait_cycles <= 2) ? 1 : $clog2(wait_cycles);
  endfunction

endpackage

// File: rtl/ram_arb_rr.sv
// Two-way round-robin grant: ptr picks the winner only when both are valid.
module ram_arb_rr (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  // One-hot (or zero) grant from valid and the priority pointer.
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbiter/sequencer sharing one asynchronous-strobe RAM between two requesters.
// Optional range check and error response: define RAM_ARB_ERR_EN.
//
// Handshake: a request transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high; a requester holds valid and payload until then.
// req_ready is only ever high in IDLE and is one-hot. rsp_valid is a one-cycle
// pulse to the owner; rsp_rdata/rsp_err are meaningful only while it is high.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int          ADDR_W        = 32,
  parameter int          DATA_W        = 32,
  parameter int          WAIT_CYCLES   = 2,
  parameter logic [31:0] START_ADDRESS = 32'h10010000,
  parameter int          MEM_BYTES     = 128
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ-1:0]        req_bw,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic [ADDR_W-1:0]       mem_addr,
  inout  wire  [DATA_W-1:0]       mem_data,
  output logic                    mem_ce_n,
  output logic                    mem_we_n,
  output logic                    mem_oe_n,
  output logic                    mem_bw,
  output logic [1:0]              state_dbg
);

  localparam int CNT_W = wait_cnt_w(WAIT_CYCLES);

  if (DATA_W != 32 || ADDR_W > ADDR_MAX_W || WAIT_CYCLES < 1 || WAIT_CYCLES > 15 ||
      MEM_BYTES < 1 || START_ADDRESS[1:0] != 2'b00) begin : g_bad_params
    $error("ram_arbiter: unsupported parameter set");
  end

  state_t          state_q, state_d;
  req_t            lat_q;
  req_t            sel_req;
  logic            owner_q;
  logic            ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]      grant;
  logic            gnt_idx;
  logic            accept;
  logic            range_err;
  logic            bus_drive;

  ram_arb_rr u_rr (
    .valid (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  assign gnt_idx = grant[1];
  assign accept  = (state_q == IDLE) && (grant != 2'b00);

  // Payload of the granted requester.
  always_comb begin
    sel_req.we    = req_we[gnt_idx];
    sel_req.bw    = req_bw[gnt_idx];
    sel_req.addr  = gnt_idx ? ADDR_MAX_W'(req_addr[2*ADDR_W-1:ADDR_W])
                            : ADDR_MAX_W'(req_addr[ADDR_W-1:0]);
    sel_req.wdata = gnt_idx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
  end

`ifdef RAM_ARB_ERR_EN
  logic        err_q;
  logic [32:0] acc_end;
  logic [32:0] win_end;

  // Window check on the request being accepted (33-bit math avoids wrap).
  always_comb begin
    acc_end   = {1'b0, sel_req.addr} + (sel_req.bw ? 33'd4 : 33'd1);
    win_end   = {1'b0, START_ADDRESS} + 33'(MEM_BYTES);
    range_err = (sel_req.addr < START_ADDRESS) || (acc_end > win_end);
  end

  // Error flag belongs to the accepted request.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= range_err;
    end
  end

  assign rsp_err = (state_q == RESP) && err_q;
`else
  assign range_err = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  // State, latched request, wait counter, read data and priority pointer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      lat_q   <= '0;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            lat_q   <= sel_req;
            owner_q <= gnt_idx;
            cnt_q   <= CNT_W'(WAIT_CYCLES - 1);
            rdata_q <= '0;
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            if (!lat_q.we) begin
              rdata_q <= lat_q.bw ? mem_data : {{(DATA_W-8){1'b0}}, mem_data[7:0]};
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          ptr_q <= ~owner_q;
        end
        default: ;
      endcase
    end
  end

  // Next-state: IDLE -> ACCESS -> RESP -> IDLE; a range error skips ACCESS.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = range_err ? RESP : ACCESS;
      ACCESS:  if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes, ready and response decode from the current state.
  always_comb begin
    mem_ce_n  = 1'b1;
    mem_we_n  = 1'b1;
    mem_oe_n  = 1'b1;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    case (state_q)
      IDLE: begin
        if (reset_n) req_ready = grant;
      end
      ACCESS: begin
        mem_ce_n = 1'b0;
        if (lat_q.we) mem_we_n = 1'b0;
        else          mem_oe_n = 1'b0;
      end
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
      end
      default: ;
    endcase
  end

  // The bus is only driven while writing, so never while mem_oe_n is low.
  assign bus_drive = (state_q == ACCESS) && lat_q.we;
  assign mem_data  = bus_drive ? lat_q.wdata : {DATA_W{1'bz}};

  assign mem_addr  = ADDR_W'(lat_q.addr);
  assign mem_bw    = lat_q.bw;
  assign rsp_rdata = rdata_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a byte-addressed asynchronous RAM model.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int WAIT = 2;

  logic        clk;
  logic        reset_n;
  logic [1:0]  req_valid, req_ready, req_we, req_bw;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  wire  [31:0] mem_data;
  logic        mem_ce_n, mem_we_n, mem_oe_n, mem_bw;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  ram_arbiter #(
    .ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(WAIT),
    .START_ADDRESS(32'h10010000), .MEM_BYTES(128)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_bw(req_bw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ce_n(mem_ce_n), .mem_we_n(mem_we_n), .mem_oe_n(mem_oe_n), .mem_bw(mem_bw),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM model (128 bytes, little-endian) ----------------
  logic [7:0]  ram [0:127];
  logic [6:0]  off;
  logic [31:0] ram_rd;
  assign off    = mem_addr[6:0];
  assign ram_rd = {ram[off + 7'd3], ram[off + 7'd2], ram[off + 7'd1], ram[off]};
  assign mem_data = (!mem_ce_n && !mem_oe_n) ? ram_rd : 32'hzzzzzzzz;

  always @(posedge clk) begin
    if (!mem_ce_n && !mem_we_n) begin
      ram[off] <= mem_data[7:0];
      if (mem_bw) begin
        ram[off + 7'd1] <= mem_data[15:8];
        ram[off + 7'd2] <= mem_data[23:16];
        ram[off + 7'd3] <= mem_data[31:24];
      end
    end
  end

  initial begin
    for (int i = 0; i < 128; i++) ram[i] <= 8'h00;
    ram[7'h04] <= 8'hEF; ram[7'h05] <= 8'hBE; ram[7'h06] <= 8'hAD; ram[7'h07] <= 8'hDE;
    ram[7'h20] <= 8'h78; ram[7'h21] <= 8'h56; ram[7'h22] <= 8'h34; ram[7'h23] <= 8'h12;
    ram[7'h7C] <= 8'h0D; ram[7'h7D] <= 8'hF0; ram[7'h7E] <= 8'hAD; ram[7'h7F] <= 8'h0B;
  end

  // Expected {ce_n, oe_n, we_n, rsp_valid[1:0]} k cycles after the handshake.
  function automatic logic [4:0] exp_strobes(input logic we, input logic owner, input int k);
    if (k >= 1 && k <= WAIT) return we ? 5'b01000 : 5'b00100;
    if (k == WAIT + 1)       return owner ? 5'b11110 : 5'b11101;
    return 5'b11100;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_req(input int idx, input logic we, input logic bw,
                         input logic [31:0] addr, input logic [31:0] wdata);
    req_valid[idx]          = 1'b1;
    req_we[idx]             = we;
    req_bw[idx]             = bw;
    req_addr[idx*32 +: 32]  = addr;
    req_wdata[idx*32 +: 32] = wdata;
    #1;
  endtask

  // Returns at the handshake cycle (sampled after the falling edge).
  task automatic wait_ready(input int idx);
    bit ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (req_ready[idx]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ready_timeout req%0d: req_ready=%b, required bit %0d set", idx, req_ready, idx);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = 2'b01;
    req_we = 2'b00; req_bw = 2'b00; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({mem_ce_n, mem_we_n, mem_oe_n, mem_bw} !== 4'b1110 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem: ce/we/oe/bw=%b addr=%h, required 1110 addr 0",
               {mem_ce_n, mem_we_n, mem_oe_n, mem_bw}, mem_addr);
    end
    checks++;
    if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_req_rsp: ready=%b rsp_valid=%b rdata=%h err=%b, required all 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    checks++;
    if (state_dbg !== IDLE || (mem_data !== 32'hzzzzzzzz && mem_data !== 32'h0)) begin
      errors++;
      $display("FAIL reset_state_bus: state=%0d bus=%h, required state 0 and bus released",
               state_dbg, mem_data);
    end
    req_valid = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    set_req(1, 1'b0, 1'b1, 32'h10010004, 32'h0);
    wait_ready(1);
    for (int k = 1; k <= WAIT + 2; k++) begin
      @(negedge clk);
      checks++;
      if ({mem_ce_n, mem_oe_n, mem_we_n, rsp_valid} !== exp_strobes(1'b0, 1'b1, k)) begin
        errors++;
        $display("FAIL single_read_strobes k=%0d: got %b, required %b", k,
                 {mem_ce_n, mem_oe_n, mem_we_n, rsp_valid}, exp_strobes(1'b0, 1'b1, k));
      end
      if (k == 1) begin
        checks++;
        if (mem_addr !== 32'h10010004 || mem_bw !== 1'b1) begin
          errors++;
          $display("FAIL single_read_addr: addr=%h bw=%b, required 10010004 bw 1", mem_addr, mem_bw);
        end
        req_valid[1] = 1'b0;
      end
      if (k == WAIT + 1) begin
        checks++;
        if (rsp_rdata !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL single_read_data: got %h, required deadbeef", rsp_rdata);
        end
      end
    end
  endtask

  task automatic test_byte_write_read();
    // byte write of A5
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 32'h10010010, 32'h000000A5);
    wait_ready(0);
    for (int k = 1; k <= WAIT + 2; k++) begin
      @(negedge clk);
      checks++;
      if ({mem_ce_n, mem_oe_n, mem_we_n, rsp_valid} !== exp_strobes(1'b1, 1'b0, k)) begin
        errors++;
        $display("FAIL byte_write_strobes k=%0d: got %b, required %b", k,
                 {mem_ce_n, mem_oe_n, mem_we_n, rsp_valid}, exp_strobes(1'b1, 1'b0, k));
      end
      if (k <= WAIT) begin
        checks++;
        if (mem_data !== 32'h000000A5 || mem_bw !== 1'b0 || mem_addr !== 32'h10010010) begin
          errors++;
          $display("FAIL byte_write_bus k=%0d: data=%h bw=%b addr=%h, required 000000a5 bw 0 addr 10010010",
                   k, mem_data, mem_bw, mem_addr);
        end
      end
      if (k == WAIT + 1) begin
        checks++;
        if (rsp_rdata !== 32'h0) begin
          errors++;
          $display("FAIL byte_write_ack_data: got %h, required 0", rsp_rdata);
        end
      end
      if (k == 1) req_valid[0] = 1'b0;
    end
    // word read of the same address
    set_req(0, 1'b0, 1'b1, 32'h10010010, 32'h0);
    wait_ready(0);
    for (int k = 1; k <= WAIT + 2; k++) begin
      @(negedge clk);
      if (k == 1) req_valid[0] = 1'b0;
      if (k == WAIT + 1) begin
        checks++;
        if (rsp_valid !== 2'b01 || rsp_rdata !== 32'h000000A5) begin
          errors++;
          $display("FAIL word_readback: rsp_valid=%b data=%h, required 01 000000a5", rsp_valid, rsp_rdata);
        end
      end
    end
    // byte read zero-extends the low byte
    set_req(1, 1'b0, 1'b0, 32'h10010004, 32'h0);
    wait_ready(1);
    for (int k = 1; k <= WAIT + 2; k++) begin
      @(negedge clk);
      if (k == 1) req_valid[1] = 1'b0;
      if (k == WAIT + 1) begin
        checks++;
        if (rsp_valid !== 2'b10 || rsp_rdata !== 32'h000000EF) begin
          errors++;
          $display("FAIL byte_read_zext: rsp_valid=%b data=%h, required 10 000000ef", rsp_valid, rsp_rdata);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [0:0] exp_q[$];
    logic [0:0] exp_g;
    bit         ok;
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    @(negedge clk);
    reset_n = 1'b0;
    set_req(0, 1'b0, 1'b1, 32'h10010004, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h10010020, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    for (int n = 0; n < 4; n++) begin
      ok = 1'b0;
      for (int t = 0; t < 40; t++) begin
        if (req_ready != 2'b00) begin
          ok = 1'b1;
          break;
        end
        @(negedge clk); #1;
      end
      exp_g = exp_q.pop_front();
      checks++;
      if (!ok || req_ready !== (exp_g ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL rr_grant n=%0d: req_ready=%b, required %b", n, req_ready, exp_g ? 2'b10 : 2'b01);
      end
      for (int k = 1; k <= WAIT + 1; k++) begin
        @(negedge clk);
        checks++;
        if ({mem_ce_n, mem_oe_n, mem_we_n, rsp_valid} !== exp_strobes(1'b0, exp_g, k)) begin
          errors++;
          $display("FAIL rr_strobes n=%0d k=%0d: got %b, required %b", n, k,
                   {mem_ce_n, mem_oe_n, mem_we_n, rsp_valid}, exp_strobes(1'b0, exp_g, k));
        end
        if (k == WAIT + 1) begin
          checks++;
          if (rsp_rdata !== (exp_g ? 32'h00000078 : 32'hDEADBEEF)) begin
            errors++;
            $display("FAIL rr_data n=%0d: got %h, required %h", n, rsp_rdata,
                     exp_g ? 32'h00000078 : 32'hDEADBEEF);
          end
        end
      end
      @(negedge clk); #1;
    end
    req_valid = 2'b00;
  endtask

  task automatic test_back_to_back();
    int       accesses = 0;
    int       gap = 0;
    logic     prev_ce_n = 1'b1;
    logic [4:0] exp_s;
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 32'h10010020, 32'hCAFEF00D);
    set_req(1, 1'b0, 1'b1, 32'h10010020, 32'h0);
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL b2b_first_grant: req_ready=%b, required 01", req_ready);
    end
    for (int n = 1; n <= 2 * WAIT + 4; n++) begin
      @(negedge clk);
      exp_s = (n <= WAIT + 1) ? exp_strobes(1'b1, 1'b0, n) : exp_strobes(1'b0, 1'b1, n - (WAIT + 2));
      checks++;
      if ({mem_ce_n, mem_oe_n, mem_we_n, rsp_valid} !== exp_s) begin
        errors++;
        $display("FAIL b2b_strobes n=%0d: got %b, required %b", n,
                 {mem_ce_n, mem_oe_n, mem_we_n, rsp_valid}, exp_s);
      end
      if (!mem_oe_n || !mem_we_n) begin
        checks++;
        if (mem_data !== 32'hCAFEF00D || (!mem_oe_n && !mem_we_n)) begin
          errors++;
          $display("FAIL b2b_bus_active n=%0d: data=%h oe_n=%b we_n=%b, required cafef00d one strobe",
                   n, mem_data, mem_oe_n, mem_we_n);
        end
      end
      if (mem_ce_n) begin
        checks++;
        if (mem_data !== 32'hzzzzzzzz && mem_data !== 32'h0) begin
          errors++;
          $display("FAIL b2b_bus_release n=%0d: data=%h, required released", n, mem_data);
        end
      end
      if (n == WAIT + 2) begin
        checks++;
        if (req_ready !== 2'b10) begin
          errors++;
          $display("FAIL b2b_second_grant: req_ready=%b, required 10", req_ready);
        end
      end
      if (n == 2 * WAIT + 3) begin
        checks++;
        if (rsp_rdata !== 32'hCAFEF00D) begin
          errors++;
          $display("FAIL b2b_read_data: got %h, required cafef00d", rsp_rdata);
        end
      end
      if (!mem_ce_n && prev_ce_n) accesses++;
      if (mem_ce_n && accesses == 1) gap++;
      prev_ce_n = mem_ce_n;
      if (n == 1)        req_valid[0] = 1'b0;
      if (n == WAIT + 3) req_valid[1] = 1'b0;
    end
    checks++;
    if (accesses != 2 || gap < 2) begin
      errors++;
      $display("FAIL b2b_gap: accesses=%0d gap=%0d, required 2 accesses gap>=2", accesses, gap);
    end
  endtask

  task automatic test_reset_mid_access();
    logic bad_rsp = 1'b0;
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 32'h10010030, 32'h0000005A);
    wait_ready(0);
    @(negedge clk);
    checks++;
    if (mem_ce_n !== 1'b0 || mem_we_n !== 1'b0 || state_dbg !== ACCESS) begin
      errors++;
      $display("FAIL midreset_pre: ce_n=%b we_n=%b state=%0d, required 0 0 1", mem_ce_n, mem_we_n, state_dbg);
    end
    req_valid[0] = 1'b0;
    reset_n      = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_ce_n, mem_oe_n, mem_we_n} !== 3'b111 || rsp_valid !== 2'b00 || state_dbg !== IDLE ||
        (mem_data !== 32'hzzzzzzzz && mem_data !== 32'h0)) begin
      errors++;
      $display("FAIL midreset_post: strobes=%b rsp_valid=%b state=%0d bus=%h, required 111 00 0 released",
               {mem_ce_n, mem_oe_n, mem_we_n}, rsp_valid, state_dbg, mem_data);
    end
    reset_n = 1'b1;
    repeat (WAIT + 4) begin
      @(negedge clk);
      if (rsp_valid !== 2'b00 || mem_ce_n !== 1'b1) bad_rsp = 1'b1;
    end
    checks++;
    if (bad_rsp) begin
      errors++;
      $display("FAIL midreset_no_rsp: stray response or access after reset, required none");
    end
  endtask

  task automatic test_window_edge();
    set_req(0, 1'b0, 1'b1, 32'h1001007C, 32'h0);
    wait_ready(0);
    for (int k = 1; k <= WAIT + 2; k++) begin
      @(negedge clk);
      if (k == 1) req_valid[0] = 1'b0;
      checks++;
      if ({mem_ce_n, mem_oe_n, mem_we_n, rsp_valid} !== exp_strobes(1'b0, 1'b0, k)) begin
        errors++;
        $display("FAIL edge_strobes k=%0d: got %b, required %b", k,
                 {mem_ce_n, mem_oe_n, mem_we_n, rsp_valid}, exp_strobes(1'b0, 1'b0, k));
      end
      if (k == WAIT + 1) begin
        checks++;
        if (rsp_rdata !== 32'h0BADF00D || rsp_err !== 1'b0) begin
          errors++;
          $display("FAIL edge_data: data=%h err=%b, required 0badf00d 0", rsp_rdata, rsp_err);
        end
      end
    end
  endtask

`ifdef RAM_ARB_ERR_EN
  task automatic test_range_err();
    logic [31:0] bad_addr [2];
    bad_addr[0] = 32'h1001007E;
    bad_addr[1] = 32'h1000FFFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      set_req(1, 1'b0, (i == 0), bad_addr[i], 32'h0);
      wait_ready(1);
      @(negedge clk);
      req_valid[1] = 1'b0;
      checks++;
      if ({mem_ce_n, mem_oe_n, mem_we_n} !== 3'b111 || rsp_valid !== 2'b10 || rsp_err !== 1'b1 ||
          rsp_rdata !== 32'h0 || state_dbg !== RESP) begin
        errors++;
        $display("FAIL range_err_rsp i=%0d: strobes=%b rsp_valid=%b err=%b data=%h state=%0d, required 111 10 1 0 2",
                 i, {mem_ce_n, mem_oe_n, mem_we_n}, rsp_valid, rsp_err, rsp_rdata, state_dbg);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 2'b00 || mem_ce_n !== 1'b1 || state_dbg !== IDLE) begin
        errors++;
        $display("FAIL range_err_after i=%0d: rsp_valid=%b ce_n=%b state=%0d, required 00 1 0",
                 i, rsp_valid, mem_ce_n, state_dbg);
      end
    end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single_read();
    test_byte_write_read();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_access();
    test_window_edge();
`ifdef RAM_ARB_ERR_EN
    test_range_err();
`endif
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
